// File: rtl/pbkdf2_dk_assembler.sv
// Concatenates PBKDF2 block outputs T_1..T_n into a dkLen-byte key and streams it as 32-bit words.
// Optional PBKDF2_DK_ZEROIZE_EN clears the block buffer at completion and forces data_o to 0 while idle.
module pbkdf2_dk_assembler #(
  parameter int unsigned DKLEN_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [DKLEN_W-1:0] dklen_i,
  output logic               busy_o,
  input  logic               chunk_v_i,
  output logic               chunk_r_o,
  input  logic [255:0]       chunk_i,
  output logic [31:0]        blk_idx_o,
  output logic [31:0]        data_o,
  output logic [3:0]         keep_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               last_o,
  output logic               done_o
);

  localparam int unsigned CHUNK_W = 256;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned KEEP_W  = 4;
  localparam int unsigned WSEL_W  = 3;
  localparam int unsigned PICK_W  = WORD_W + KEEP_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT} state_e;

  state_e               state_q, state_d;
  logic [DKLEN_W-1:0]   bytes_left_q, bytes_left_d;
  logic [31:0]          blk_idx_q, blk_idx_d;
  logic [CHUNK_W-1:0]   buf_q, buf_d;
  logic [WSEL_W-1:0]    word_q, word_d;
  logic [WORD_W-1:0]    data_q, data_d;
  logic [KEEP_W-1:0]    keep_q, keep_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 chunk_r_q, chunk_r_d;
  logic [DKLEN_W-1:0]   bl_next;
  logic [PICK_W-1:0]    pick;

  // Select word idx of a block and shape keep/last/masking from the bytes still owed.
  function automatic logic [PICK_W-1:0] pick_word(input logic [CHUNK_W-1:0] blk,
                                                  input logic [WSEL_W-1:0]  idx,
                                                  input logic [DKLEN_W-1:0] bl);
    logic [CHUNK_W-1:0] sh;
    logic [KEEP_W-1:0]  kp;
    logic [WORD_W-1:0]  wd;
    logic               lst;
    sh = blk << {idx, 5'd0};
    if (bl >= DKLEN_W'(4)) begin
      kp = 4'b1111;
    end else begin
      case (bl[1:0])
        2'd1:    kp = 4'b1000;
        2'd2:    kp = 4'b1100;
        2'd3:    kp = 4'b1110;
        default: kp = 4'b1111;
      endcase
    end
    lst = (bl <= DKLEN_W'(4));
    wd  = sh[CHUNK_W-1 -: WORD_W] & {{8{kp[3]}}, {8{kp[2]}}, {8{kp[1]}}, {8{kp[0]}}};
    return {lst, kp, wd};
  endfunction

  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    blk_idx_d    = blk_idx_q;
    buf_d        = buf_q;
    word_d       = word_q;
    data_d       = data_q;
    keep_d       = keep_q;
    valid_d      = valid_q;
    last_d       = last_q;
    done_d       = 1'b0;
    pick         = '0;
    bl_next      = (bytes_left_q > DKLEN_W'(4)) ? bytes_left_q - DKLEN_W'(4) : '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (dklen_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = S_WAIT;
            bytes_left_d = dklen_i;
            blk_idx_d    = 32'd1;
          end
        end
      end
      S_WAIT: begin
        if (chunk_v_i && chunk_r_q) begin
          buf_d                   = chunk_i;
          pick                    = pick_word(chunk_i, '0, bytes_left_q);
          {last_d, keep_d, data_d} = pick;
          valid_d                 = 1'b1;
          word_d                  = '0;
          blk_idx_d               = blk_idx_q + 32'd1;
          state_d                 = S_EMIT;
        end
      end
      S_EMIT: begin
        if (ready_i) begin
          bytes_left_d = bl_next;
          if (last_q) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            done_d    = 1'b1;
            blk_idx_d = '0;
            word_d    = '0;
`ifdef PBKDF2_DK_ZEROIZE_EN
            buf_d     = '0;
`endif
          end else if (word_q == WSEL_W'(7)) begin
            state_d = S_WAIT;
            valid_d = 1'b0;
            word_d  = '0;
          end else begin
            word_d                   = word_q + WSEL_W'(1);
            pick                     = pick_word(buf_q, word_q + WSEL_W'(1), bl_next);
            {last_d, keep_d, data_d} = pick;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef PBKDF2_DK_ZEROIZE_EN
    if (!valid_d) data_d = '0;
`endif

    busy_d    = (state_d != S_IDLE);
    chunk_r_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      bytes_left_q <= '0;
      blk_idx_q    <= '0;
      buf_q        <= '0;
      word_q       <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      chunk_r_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      blk_idx_q    <= blk_idx_d;
      buf_q        <= buf_d;
      word_q       <= word_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      chunk_r_q    <= chunk_r_d;
    end
  end

  assign busy_o    = busy_q;
  assign chunk_r_o = chunk_r_q;
  assign blk_idx_o = blk_idx_q;
  assign data_o    = data_q;
  assign keep_o    = keep_q;
  assign valid_o   = valid_q;
  assign last_o    = last_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_pbkdf2_dk_assembler.sv
// Directed bench for pbkdf2_dk_assembler: scoreboard of expected key words built from a byte-level model.
module tb_pbkdf2_dk_assembler;

  localparam int unsigned DKLEN_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_i;
  logic [DKLEN_W-1:0] dklen_i;
  logic               busy_o;
  logic               chunk_v_i;
  logic               chunk_r_o;
  logic [255:0]       chunk_i;
  logic [31:0]        blk_idx_o;
  logic [31:0]        data_o;
  logic [3:0]         keep_o;
  logic               valid_o;
  logic               ready_i;
  logic               last_o;
  logic               done_o;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          tog = 1'b0;
  bit          last_seen = 1'b0;
  logic [31:0] last_data = '0;
  word_t       prev_w;
  bit          prev_stall = 1'b0;
  int unsigned rem_g = 0;
  logic [255:0] c_a, c_b, c_c, c_d;

  always #5 clk = ~clk;

  pbkdf2_dk_assembler #(.DKLEN_W(DKLEN_W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start_i),
    .dklen_i  (dklen_i),
    .busy_o   (busy_o),
    .chunk_v_i(chunk_v_i),
    .chunk_r_o(chunk_r_o),
    .chunk_i  (chunk_i),
    .blk_idx_o(blk_idx_o),
    .data_o   (data_o),
    .keep_o   (keep_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .last_o   (last_o),
    .done_o   (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [255:0] c, input int k);
    return 8'(c >> (8 * (31 - k)));
  endfunction

  function automatic logic [255:0] mk_chunk(input int base);
    logic [255:0] c;
    c = '0;
    for (int k = 0; k < 32; k++) c[255 - 8*k -: 8] = 8'(base + k);
    return c;
  endfunction

  // Expected words for one block, derived byte by byte from the bytes still owed.
  task automatic push_chunk(input logic [255:0] c);
    int    nw;
    word_t e;
    logic [31:0] d;
    logic [3:0]  kp;
    nw = (rem_g >= 32) ? 8 : int'((rem_g + 3) / 4);
    for (int w = 0; w < nw; w++) begin
      d  = '0;
      kp = '0;
      for (int b = 0; b < 4; b++) begin
        if (4*w + b < int'(rem_g)) begin
          d[31 - 8*b -: 8] = byte_of(c, 4*w + b);
          kp[3 - b] = 1'b1;
        end
      end
      e.data = d;
      e.keep = kp;
      e.last = (int'(rem_g) <= 4*w + 4);
      sb.push_back(e);
    end
    rem_g = (rem_g >= 32) ? rem_g - 32 : 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) ready_i = ~ready_i;
  endtask

  task automatic start_job(input int unsigned dk);
    start_i = 1'b1;
    dklen_i = DKLEN_W'(dk);
    rem_g   = dk;
    step();
    start_i = 1'b0;
    chk("start_busy", 64'(busy_o), 64'd1);
    chk("start_chunk_r", 64'(chunk_r_o), 64'd1);
    chk("start_blk_idx", 64'(blk_idx_o), 64'd1);
  endtask

  task automatic feed_chunk(input logic [255:0] c, input int unsigned exp_idx);
    bit got;
    got = 1'b0;
    push_chunk(c);
    chunk_v_i = 1'b1;
    chunk_i   = c;
    for (int i = 0; i < 400 && !got; i++) begin
      if (chunk_r_o) begin
        chk("bubble_valid", 64'(valid_o), 64'd0);
        chk("blk_idx", 64'(blk_idx_o), 64'(exp_idx));
        got = 1'b1;
      end
      step();
    end
    chunk_v_i = 1'b0;
    chunk_i   = '1;
    if (!got) chk("chunk_timeout", 64'd0, 64'd1);
    else      chk("chunk_latency", 64'(valid_o), 64'd1);
  endtask

  task automatic wait_done();
    bit got;
    logic [31:0] exp_data;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (last_seen) begin
        last_seen = 1'b0;
        got = 1'b1;
        chk("done_pulse", 64'(done_o), 64'd1);
        chk("done_busy", 64'(busy_o), 64'd0);
        chk("done_blk_idx", 64'(blk_idx_o), 64'd0);
        chk("done_valid", 64'(valid_o), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
`ifdef PBKDF2_DK_ZEROIZE_EN
        exp_data = '0;
`else
        exp_data = last_data;
`endif
        chk("data_after_done", 64'(data_o), 64'(exp_data));
      end else begin
        chk("early_done", 64'(done_o), 64'd0);
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    step();
    chk("done_one_cycle", 64'(done_o), 64'd0);
  endtask

  // Output monitor: pops the scoreboard on every accepted word and checks stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o) begin
        if (prev_stall) chk("stall_stable", 64'({data_o, keep_o, last_o}), 64'(prev_w));
        if (ready_i) begin
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL extra_word: observed %0h expected no word", data_o);
          end
          if (sb.size() != 0) begin
            word_t w;
            w = sb.pop_front();
            chk("word", 64'({data_o, keep_o, last_o}), 64'(w));
            if (w.last) begin
              last_seen = 1'b1;
              last_data = w.data;
            end
          end
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_w     = {data_o, keep_o, last_o};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    rst_n     = 1'b0;
    start_i   = 1'b0;
    dklen_i   = '0;
    chunk_v_i = 1'b0;
    chunk_i   = '0;
    ready_i   = 1'b1;
    c_a = mk_chunk(8'h00);
    c_b = mk_chunk(8'h40);
    c_c = mk_chunk(8'h80);
    c_d = {32'hDEADBEEF, 224'h0123456789ABCDEF0123456789ABCDEF0123456789ABCDEF01234567};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_chunk_r", 64'(chunk_r_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_outs", 64'({data_o, keep_o, last_o, done_o}), 64'd0);
    chk("rst_blk_idx", 64'(blk_idx_o), 64'd0);
    rst_n = 1'b1;
    step();

    // 32-byte key from a single block
    start_job(32);
    feed_chunk(c_a, 1);
    chk("t32_word0", 64'(data_o), 64'h00010203);
    chk("t32_blk_idx2", 64'(blk_idx_o), 64'd2);
    wait_done();

    // 70-byte key across three blocks with truncated tail
    start_job(70);
    feed_chunk(c_a, 1);
    feed_chunk(c_b, 2);
    feed_chunk(c_c, 3);
    wait_done();

    // 20-byte key under alternating back-pressure
    tog = 1'b1;
    start_job(20);
    feed_chunk(c_b, 1);
    wait_done();
    tog = 1'b0;
    ready_i = 1'b1;

    // zero-length key
    start_i = 1'b1;
    dklen_i = '0;
    step();
    start_i = 1'b0;
    chk("zero_done", 64'(done_o), 64'd1);
    chk("zero_busy", 64'(busy_o), 64'd0);
    chk("zero_chunk_r", 64'(chunk_r_o), 64'd0);
    step();
    chk("zero_done_drop", 64'(done_o), 64'd0);
    chk("zero_chunk_r2", 64'(chunk_r_o), 64'd0);
    chk("zero_valid", 64'(valid_o), 64'd0);

    // reset while presenting word 3 of 8
    ready_i = 1'b0;
    start_job(32);
    feed_chunk(c_a, 1);
    ready_i = 1'b1;
    repeat (3) step();
    ready_i = 1'b0;
    chk("pre_rst_word3", 64'(data_o), 64'h0C0D0E0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_outs", 64'({data_o, keep_o, last_o, done_o, chunk_r_o}), 64'd0);
    chk("mid_rst_blk_idx", 64'(blk_idx_o), 64'd0);
    sb.delete();
    last_seen = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_no_done", 64'(done_o), 64'd0);
    ready_i = 1'b1;
    start_job(4);
    feed_chunk(c_d, 1);
    chk("dk4_keep", 64'(keep_o), 64'hF);
    chk("dk4_last", 64'(last_o), 64'd1);
    chk("dk4_data", 64'(data_o), 64'hDEADBEEF);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pbkdf2_dk_assembler.md
# pbkdf2_dk_assembler

Downstream stage of the PBKDF2 chunk engine. Consumes the 256-bit block outputs T_1, T_2, … produced per block index, concatenates them into the derived key DK of a requested byte length, truncates the final block, and streams DK out as 32-bit words with valid/ready, byte-keep and last. Also publishes the block index the chunk engine must compute next, so the upstream salt builder can form salt || INT(i).

## Interface

Parameters:
- DKLEN_W, 16, width of the requested key length in bytes. Maximum dkLen is 2^DKLEN_W − 1.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  reset. It is asynchronous and active-low.
- start_i  in  1  begin a new key; sampled only in IDLE.
- dklen_i  in  DKLEN_W  requested DK length in bytes; sampled with start_i.
- busy_o  out  1  high in any state other than IDLE.
- chunk_v_i  in  1  chunk engine output valid.
- chunk_r_o  out  1  ready for a chunk; high only in WAIT.
- chunk_i  in  256  T_i; byte 0 is chunk_i[255:248].
- blk_idx_o  out  32  1-based block index expected next; 0 when idle.
- data_o  out  32  key word; first key byte is data_o[31:24].
- keep_o  out  4  valid-byte mask, MSB = first byte.
- valid_o  out  1  data_o valid.
- ready_i  in  1  downstream accepts the word.
- last_o  out  1  final word of DK; qualified by valid_o.
- done_o  out  1  one-cycle pulse after the last word is accepted, or for the dkLen = 0 case.

## Operation

- States:
  - IDLE: start_i with dklen_i ≠ 0 moves to WAIT. start_i with dklen_i = 0 stays in IDLE and pulses done_o next cycle.
  - WAIT: chunk_r_o = 1. A chunk_v_i && chunk_r_o handshake loads the 256-bit buffer and moves to EMIT.
  - EMIT: presents buffer word w (0..7). It advances on valid_o && ready_i.
    - After the final DK word, go to IDLE and pulse done_o.
    - After word 7 of a non-final chunk, go to WAIT.
- On start: latch bytes_left = dklen_i and set blk_idx_o = 1. blk_idx_o increments on each chunk handshake. It clears to 0 when returning to IDLE.
- Word count is ceil(dklen/4). Each chunk supplies 8 words; the final chunk supplies ceil(remaining/4) words. Unused buffer words are discarded.
- Final word:
  - last_o = 1.
  - keep_o by dklen mod 4: 0 → 1111, 1 → 1000, 2 → 1100, 3 → 1110.
  - Masked bytes of data_o are driven to 0.
- Non-final words: keep_o = 1111, last_o = 0.
- start_i is ignored while busy.
- chunk_v_i is ignored outside WAIT; no chunk is ever dropped once accepted.
- Arithmetic: bytes_left is DKLEN_W bits wide and is decremented by 4, saturating at 0. blk_idx_o cannot wrap, since the block count is at most 2^(DKLEN_W−5)+1.

## Timing

- Reset (rst_ni low, asynchronous) forces:
  - state = IDLE;
  - busy_o = chunk_r_o = valid_o = last_o = done_o = 0;
  - data_o = 0, keep_o = 0, blk_idx_o = 0;
  - buffer cleared.
  - Reset mid-operation abandons the key; no done_o pulse.
- start_i at edge N gives busy_o = 1, chunk_r_o = 1 and blk_idx_o = 1 in cycle N+1.
- A chunk handshake at edge N gives valid_o = 1 with word 0 in cycle N+1 (latency 1).
- With ready_i held high, one word is output per cycle. Data, keep and last stay stable while valid_o && !ready_i.
- After word 7 of a non-final chunk is accepted at edge N, chunk_r_o = 1 in cycle N+1. This gives one bubble per chunk boundary.
- When the last word is accepted at edge N:
  - done_o = 1 and busy_o = 0 in cycle N+1;
  - a new start_i is accepted in that same cycle.

## Configuration

- PBKDF2_DK_ZEROIZE_EN:
  - Defined: the buffer is cleared to 0 on the cycle the final word is accepted. data_o reads 0 whenever valid_o = 0.
  - Undefined: the buffer and data_o retain their last values after completion; only valid_o drops.

## Test plan

- dklen = 32, one chunk 0x00010203…1F with ready_i = 1:
  - 8 words 0x00010203 … 0x1C1D1E1F;
  - last_o on word 7 with keep 1111;
  - done_o one cycle later; blk_idx_o goes 1 → 2 → 0.
- dklen = 70, three chunks:
  - 16 full words, then 2 words from chunk 3;
  - last word keep 1100 with low 16 bits = 0;
  - blk_idx_o reaches 3; chunk_r_o bubble visible between chunks.
- dklen = 20, ready_i toggling 1010…:
  - 5 words, data stable while stalled;
  - last keep 1111 with no missing or duplicated words.
- dklen = 0: done_o pulses one cycle after start_i; chunk_r_o never asserts and no words are output.
- rst_ni low mid-EMIT (word 3 of 8):
  - all outputs 0 immediately;
  - a subsequent dklen = 4 job returns keep 1111 and last_o on the first word.
- Macro on/off, read data_o after done_o: defined → 0; undefined → last key word.
